pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush controller for the 5-stage pipeline. It merges per-stage stall requests into the 6-bit `stall` vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. It turns exceptions reported by the mem stage into a pipeline-wide `flush` plus a redirect PC. An exception that arrives while a data-memory access is outstanding is held until the access completes. The block also counts stall cycles for performance monitoring.

## Interface
Parameters:
- `EXC_VECTOR`, 32'h00000020, redirect target for every exception except eret.
- `ERET_TYPE`, 32'h0000000e, `excepttype_i` code meaning eret (redirect to EPC).

Ports:
- `clk`  in  1  pipeline clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `stallreq_if`  in  1  fetch stage waiting on instruction memory.
- `stallreq_id`  in  1  load-use hazard detected in decode.
- `stallreq_ex`  in  1  multi-cycle ALU op (div/madd) busy.
- `stallreq_mem`  in  1  data-memory access outstanding.
- `excepttype_i`  in  32  exception code from the mem stage; nonzero means an exception.
- `cp0_epc_i`  in  32  current EPC from CP0.
- `stall_cnt_clr`  in  1  synchronous clear of `stall_cycles`.
- `stall`  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold.
- `flush`  out  1  one-cycle pipeline flush.
- `new_pc`  out  32  redirect PC; valid only while `flush`=1, otherwise 0.
- `stall_cycles`  out  32  saturating count of cycles with `stall[0]`=1.

## Operation
- Stall encoding, highest requester wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000111
  - none → 6'b000000
- FSM states:
  - RUN (reset state).
  - PEND: exception latched, waiting for the memory access to finish.
  - FLUSHED: one bubble cycle after a flush.
- RUN:
  - `excepttype_i`≠0 and `stallreq_mem`=0 → `flush`=1, `stall`=0, `new_pc` from the live inputs; next state FLUSHED.
  - `excepttype_i`≠0 and `stallreq_mem`=1 → latch `excepttype_i` and `cp0_epc_i`; `stall`=6'b011111, `flush`=0; next state PEND.
  - No exception → normal stall encoding.
- PEND:
  - `stallreq_mem`=1 → `stall`=6'b011111.
  - `stallreq_mem`=0 → `flush`=1, `stall`=0, `new_pc` from the latched values; next state FLUSHED.
  - New `excepttype_i` values are ignored; the latched exception wins.
  - EPC is taken from the latch, not the live `cp0_epc_i`.
- FLUSHED:
  - `stall`=0 and `flush`=0 regardless of inputs; requests come from flushed instructions.
  - `excepttype_i` is ignored.
  - Next state RUN.
- `new_pc` mapping: exception type == `ERET_TYPE` → EPC; any other nonzero type → `EXC_VECTOR`.
- `stall`, `flush` and `new_pc` are combinational from the state register, the latches and the inputs. This gives zero-latency stalls.
- `stall_cycles`:
  - Increments on each clock edge where `stall[0]`=1.
  - Saturates at 32'hFFFFFFFF.
  - `stall_cnt_clr` has priority over increment (clear wins).

## Timing
- Reset values: state RUN, latched type/EPC 0, `stall_cycles` 0.
- While `rst`=1: `stall`=0, `flush`=0, `new_pc`=0.
- Reset mid-PEND discards the latched exception; no flush is issued.
- Stall latency: 0 cycles; `stall` reflects requests in the same cycle.
- Flush pulse width is exactly 1 cycle. It is always followed by exactly 1 FLUSHED cycle.
- Exception during a mem stall: the flush occurs in the first cycle with `stallreq_mem`=0, the same cycle the access completes.
- Simultaneous exception and any if/id/ex request with mem idle: flush wins and `stall`=0.
- Counter updates are registered; `stall_cycles` lags `stall[0]` by one edge.

## Test plan
- Priority: assert if+id+ex+mem together → `stall`=6'b011111. Drop mem → 6'b001111. Drop ex → 6'b000111. Drop id with if still held → 6'b000111.
- Immediate exception:
  - `excepttype_i`=32'h8, mem idle → same cycle `flush`=1, `new_pc`=32'h20, `stall`=0.
  - Next cycle, with `stallreq_id`=1 → `stall`=0, `flush`=0.
  - Cycle after that → `stall`=6'b000111.
- Eret: `excepttype_i`=32'he, `cp0_epc_i`=32'h00400104 → `flush`=1, `new_pc`=32'h00400104.
- Deferred flush:
  - Hold `stallreq_mem`=1 for 4 cycles. In cycle 1, `excepttype_i`=32'he with EPC 32'h1000; in cycle 2, change EPC to 32'h2000 and type to 32'h8.
  - Required: `stall`=6'b011111 throughout, then one `flush` with `new_pc`=32'h1000 in the cycle mem drops.
- Reset mid-PEND: reset while in PEND, then drop mem → no flush; `stall_cycles`=0.
- Counter:
  - 10 stalled cycles → `stall_cycles`=10.
  - Assert `stall_cnt_clr` during a stall → 0.
  - Preload to near-saturation via a long stall (or force) → holds at 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush controller
// Merges stage stall requests, defers mem-stage exceptions behind data accesses, counts stall cycles.
module pipeline_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h00000020,
   parameter logic [31:0] ERET_TYPE  = 32'h0000000e
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        stall_cnt_clr,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      PEND    = 2'd1,
      FLUSHED = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] exc_type_q;
   logic [31:0] epc_q;
   logic        latch_en;
   logic [5:0]  stall_req;

   function automatic logic [31:0] redirect(input logic [31:0] etype, input logic [31:0] epc);
      return (etype == ERET_TYPE) ? epc : EXC_VECTOR;
   endfunction

   always_comb begin
      stall_req = 6'b000000;
      if (stallreq_mem)
         stall_req = 6'b011111;
      else if (stallreq_ex)
         stall_req = 6'b001111;
      else if (stallreq_id || stallreq_if)
         stall_req = 6'b000111;
   end

   always_comb begin
      state_nxt = state;
      stall     = 6'b000000;
      flush     = 1'b0;
      new_pc    = 32'h0;
      latch_en  = 1'b0;
      if (!rst) begin
         case (state)
            RUN: begin
               if (excepttype_i != 32'h0) begin
                  if (stallreq_mem) begin
                     stall     = 6'b011111;
                     latch_en  = 1'b1;
                     state_nxt = PEND;
                  end else begin
                     flush     = 1'b1;
                     new_pc    = redirect(excepttype_i, cp0_epc_i);
                     state_nxt = FLUSHED;
                  end
               end else begin
                  stall = stall_req;
               end
            end
            PEND: begin
               // The latched exception wins over anything arriving while mem is busy.
               if (stallreq_mem) begin
                  stall = 6'b011111;
               end else begin
                  flush     = 1'b1;
                  new_pc    = redirect(exc_type_q, epc_q);
                  state_nxt = FLUSHED;
               end
            end
            FLUSHED: state_nxt = RUN;
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         exc_type_q <= 32'h0;
         epc_q      <= 32'h0;
      end else begin
         state <= state_nxt;
         if (latch_en) begin
            exc_type_q <= excepttype_i;
            epc_q      <= cp0_epc_i;
         end
      end
   end

   // Clear beats increment; the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst || stall_cnt_clr)
         stall_cycles <= 32'h0;
      else if (stall[0] && (stall_cycles != 32'hFFFFFFFF))
         stall_cycles <= stall_cycles + 32'h1;
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard testbench for pipeline_ctrl
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
   logic [31:0] excepttype_i = 32'h0, cp0_epc_i = 32'h0;
   logic        stall_cnt_clr = 1'b0;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc, stall_cycles;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic        chk_cnt;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];

   pipeline_ctrl dut (
      .clk(clk), .rst(rst),
      .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
      .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
      .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
      .stall_cnt_clr(stall_cnt_clr),
      .stall(stall), .flush(flush), .new_pc(new_pc), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // inputs: {rst, if, id, ex, mem, clr}
   task automatic step(input string name, input logic [5:0] in, input logic [31:0] et,
                       input logic [31:0] epc, input logic [5:0] e_stall, input logic e_flush,
                       input logic [31:0] e_pc, input logic chk, input logic [31:0] e_cnt);
      exp_t e;
      @(posedge clk);
      #1;
      {rst, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, stall_cnt_clr} = in;
      excepttype_i = et;
      cp0_epc_i    = epc;
      e.name = name; e.stall = e_stall; e.flush = e_flush; e.pc = e_pc;
      e.chk_cnt = chk; e.cnt = e_cnt;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (stall !== e.stall || flush !== e.flush || new_pc !== e.pc) begin
            errors++;
            $display("FAIL %s: got stall=%b flush=%b new_pc=%h, want stall=%b flush=%b new_pc=%h",
                     e.name, stall, flush, new_pc, e.stall, e.flush, e.pc);
         end
         if (e.chk_cnt) begin
            checks++;
            if (stall_cycles !== e.cnt) begin
               errors++;
               $display("FAIL %s cnt: got stall_cycles=%0h, want %0h", e.name, stall_cycles, e.cnt);
            end
         end
      end
   end

   initial begin
      step("reset0", 6'b100010, 32'h8, 32'h0, 6'b000000, 0, 0, 1, 0);
      step("reset1", 6'b111110, 32'h8, 32'h0, 6'b000000, 0, 0, 1, 0);
      // priority
      step("all",    6'b011110, 0, 0, 6'b011111, 0, 0, 1, 0);
      step("no_mem", 6'b011100, 0, 0, 6'b001111, 0, 0, 1, 1);
      step("no_ex",  6'b011000, 0, 0, 6'b000111, 0, 0, 1, 2);
      step("if_only",6'b010000, 0, 0, 6'b000111, 0, 0, 1, 3);
      step("idle0",  6'b000000, 0, 0, 6'b000000, 0, 0, 1, 4);
      step("clr",    6'b000001, 0, 0, 6'b000000, 0, 0, 1, 4);
      step("cleared",6'b000000, 0, 0, 6'b000000, 0, 0, 1, 0);
      // immediate exception beats id stall, then one bubble
      step("exc_imm",  6'b001000, 32'h8, 0, 6'b000000, 1, 32'h20, 0, 0);
      step("bubble",   6'b001000, 32'h8, 0, 6'b000000, 0, 0, 0, 0);
      step("after_bub",6'b001000, 0, 0, 6'b000111, 0, 0, 0, 0);
      step("idle1",    6'b000000, 0, 0, 6'b000000, 0, 0, 1, 1);
      // eret
      step("eret",   6'b000000, 32'he, 32'h00400104, 6'b000000, 1, 32'h00400104, 0, 0);
      step("eret_b", 6'b000000, 0, 0, 6'b000000, 0, 0, 0, 0);
      step("idle2",  6'b000000, 0, 0, 6'b000000, 0, 0, 0, 0);
      // deferred flush: latched eret/EPC wins
      step("pend1",  6'b000010, 32'he, 32'h1000, 6'b011111, 0, 0, 0, 0);
      step("pend2",  6'b000010, 32'h8, 32'h2000, 6'b011111, 0, 0, 0, 0);
      step("pend3",  6'b000010, 0, 32'h2000, 6'b011111, 0, 0, 0, 0);
      step("pend4",  6'b000010, 0, 32'h2000, 6'b011111, 0, 0, 0, 0);
      step("def_fl", 6'b000000, 0, 32'h2000, 6'b000000, 1, 32'h1000, 1, 5);
      step("def_b",  6'b000110, 32'h8, 0, 6'b000000, 0, 0, 0, 0);
      step("idle3",  6'b000000, 0, 0, 6'b000000, 0, 0, 1, 5);
      step("clr2",   6'b000001, 0, 0, 6'b000000, 0, 0, 1, 5);
      step("idle4",  6'b000000, 0, 0, 6'b000000, 0, 0, 1, 0);
      // reset while pending
      step("rp_pend",6'b000010, 32'h8, 0, 6'b011111, 0, 0, 1, 0);
      step("rp_rst", 6'b100010, 0, 0, 6'b000000, 0, 0, 1, 1);
      step("rp_drop",6'b000000, 0, 0, 6'b000000, 0, 0, 1, 0);
      step("rp_idle",6'b000000, 0, 0, 6'b000000, 0, 0, 1, 0);
      // ten stalled cycles
      for (int i = 0; i < 10; i++)
         step("ex_stall", 6'b000100, 0, 0, 6'b001111, 0, 0, 1, i);
      step("cnt10",  6'b000000, 0, 0, 6'b000000, 0, 0, 1, 10);
      step("clr_st", 6'b000101, 0, 0, 6'b001111, 0, 0, 1, 10);
      step("clr_won",6'b000100, 0, 0, 6'b001111, 0, 0, 1, 0);
      step("cnt1",   6'b000000, 0, 0, 6'b000000, 0, 0, 1, 1);
      // saturation: preload near the top, then stall past it
      @(posedge clk);
      #2 force dut.stall_cycles = 32'hFFFFFFFD;
      #1 release dut.stall_cycles;
      step("sat0", 6'b000100, 0, 0, 6'b001111, 0, 0, 1, 32'hFFFFFFFD);
      step("sat1", 6'b000100, 0, 0, 6'b001111, 0, 0, 1, 32'hFFFFFFFE);
      step("sat2", 6'b000100, 0, 0, 6'b001111, 0, 0, 1, 32'hFFFFFFFF);
      step("sat3", 6'b000100, 0, 0, 6'b001111, 0, 0, 1, 32'hFFFFFFFF);
      step("sat4", 6'b000000, 0, 0, 6'b000000, 0, 0, 1, 32'hFFFFFFFF);
      for (int i = 0; i < 20 && sb.size() > 0; i++)
         @(posedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
